// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types, defaults and helpers for the iterative multiplier.
package mult_pkg;

  localparam int WIDTH_DEF = 64;
  localparam int CTR_W_DEF = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_SIGN = 2'd2
  } state_e;

  // Most-negative input maps to 2^(W-1), which is still representable unsigned.
  function automatic logic [WIDTH_DEF-1:0] twos_mag(input logic [WIDTH_DEF-1:0] v);
    return v[WIDTH_DEF-1] ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/mult_shift_add_dp.sv
// rtl/mult_shift_add_dp.sv - shift-add datapath: one multiplier bit per step.
module mult_shift_add_dp
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   ld_a,
  input  logic [WIDTH-1:0]   ld_b,
  output logic [2*WIDTH-1:0] acc
);

  logic [2*WIDTH-1:0] ma_q, ma_d;
  logic [WIDTH-1:0]   mb_q, mb_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;

  always_comb begin
    ma_d  = ma_q;
    mb_d  = mb_q;
    acc_d = acc_q;
    if (load) begin
      ma_d  = {{WIDTH{1'b0}}, ld_a};
      mb_d  = ld_b;
      acc_d = '0;
    end else if (step) begin
      if (mb_q[0]) acc_d = acc_q + ma_q;
      ma_d = ma_q << 1;
      mb_d = mb_q >> 1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ma_q  <= '0;
      mb_q  <= '0;
      acc_q <= '0;
    end else begin
      ma_q  <= ma_d;
      mb_q  <= mb_d;
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/mult_seq_ctrl.sv
// rtl/mult_seq_ctrl.sv - DMULT/DMULTU sequencer: FSM, sign fix-up, HI/LO and read stall.
module mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CTR_W = CTR_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             abort,
  input  logic             mthi_we,
  input  logic             mtlo_we,
  input  logic [WIDTH-1:0] mt_data,
  input  logic             rd_req,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e             state_q, state_d;
  logic [CTR_W-1:0]   ctr_q, ctr_d;
  logic               neg_q, neg_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               load, step;
  logic [WIDTH-1:0]   ld_a, ld_b;
  logic [2*WIDTH-1:0] acc, res;
  logic [WIDTH_DEF-1:0] a_ext, b_ext;

  // Sign-extend into the helper's width so narrower instances keep correct magnitudes.
  assign a_ext = WIDTH_DEF'($signed(op_a));
  assign b_ext = WIDTH_DEF'($signed(op_b));
  assign ld_a  = is_signed ? WIDTH'(twos_mag(a_ext)) : op_a;
  assign ld_b  = is_signed ? WIDTH'(twos_mag(b_ext)) : op_b;

  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    neg_d   = neg_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    load    = 1'b0;
    step    = 1'b0;
    res     = neg_q ? (~acc + 1'b1) : acc;

    // MT writes land even alongside an accepted start; the product overwrites later.
    if (state_q == ST_IDLE) begin
      if (mthi_we) hi_d = mt_data;
      if (mtlo_we) lo_d = mt_data;
    end

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          load    = 1'b1;
          neg_d   = is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
          ctr_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          step  = 1'b1;
          ctr_d = ctr_q + 1'b1;
          if (ctr_q == CTR_W'(WIDTH - 1)) state_d = ST_SIGN;
        end
      end
      ST_SIGN: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
        if (!abort) begin
          {hi_d, lo_d} = res;
          done_d       = 1'b1;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ctr_q   <= '0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      neg_q   <= neg_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  mult_shift_add_dp #(.WIDTH(WIDTH)) u_dp (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .step (step),
    .ld_a (ld_a),
    .ld_b (ld_b),
    .acc  (acc)
  );

  assign busy  = busy_q;
  assign done  = done_q;
  assign stall = rd_req & busy_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb/tb_mult_seq_ctrl.sv - self-checking bench for mult_seq_ctrl.
module tb_mult_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, is_signed = 1'b0, abort = 1'b0;
  logic        mthi_we = 1'b0, mtlo_we = 1'b0, rd_req = 1'b0;
  logic [63:0] op_a = '0, op_b = '0, mt_data = '0;
  logic        busy, done, stall;
  logic [63:0] hi, lo;

  int checks = 0;
  int errors = 0;

  mult_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .op_a(op_a), .op_b(op_b), .abort(abort), .mthi_we(mthi_we),
    .mtlo_we(mtlo_we), .mt_data(mt_data), .rd_req(rd_req),
    .busy(busy), .done(done), .stall(stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && busy && (mthi_we || mtlo_we))
      $error("MT write issued while busy");
  end

  typedef struct {
    logic         s;
    logic [63:0]  a;
    logic [63:0]  b;
    logic [127:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic s, input logic [63:0] a, input logic [63:0] b);
    is_signed = s;
    op_a      = a;
    op_b      = b;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  // Runs until done is seen; lat counts edges after the start-accept edge.
  task automatic wait_done(output int lat, output int busy_cnt, output int stall_bad);
    lat = 0; busy_cnt = 0; stall_bad = 0;
    while (!done && lat < 200) begin
      if (busy) busy_cnt++;
      if (rd_req && busy && !stall) stall_bad++;
      if (!busy && stall) stall_bad++;
      tick();
      lat++;
    end
  endtask

  function automatic logic [127:0] model(input logic s, input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] sa, sb;
    if (s) begin
      sa = $signed(a);
      sb = $signed(b);
      return sa * sb;
    end
    return {64'b0, a} * {64'b0, b};
  endfunction

  initial begin
    vec_t tbl[5];
    int lat, bc, sb, lat2, cnt;
    logic s;
    logic [63:0] a, b;

    tbl[0] = '{1'b0, 64'd3, 64'd5, 128'd15};
    tbl[1] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, {128{1'b1}}};
    tbl[2] = '{1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
               {64'h4000_0000_0000_0000, 64'h0}};
    tbl[3] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               {64'hFFFF_FFFF_FFFF_FFFE, 64'h1}};
    tbl[4] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 128'd1};

    tick(); tick();
    chk("reset_busy", 128'(busy), 128'd0);
    chk("reset_done", 128'(done), 128'd0);
    chk("reset_hilo", {hi, lo}, 128'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) begin
      launch(tbl[i].s, tbl[i].a, tbl[i].b);
      wait_done(lat, bc, sb);
      chk($sformatf("tbl%0d_latency", i), 128'(lat), 128'd65);
      chk($sformatf("tbl%0d_busy_cycles", i), 128'(bc), 128'd65);
      chk($sformatf("tbl%0d_busy_in_done", i), 128'(busy), 128'd0);
      chk($sformatf("tbl%0d_result", i), {hi, lo}, tbl[i].exp);
      tick();
      chk($sformatf("tbl%0d_done_once", i), 128'(done), 128'd0);
    end

    for (int i = 0; i < 16; i++) begin
      s = 1'($urandom_range(0, 1));
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if (i == 3) a = 64'h8000_0000_0000_0000;
      if (i == 5) b = 64'd0;
      launch(s, a, b);
      wait_done(lat, bc, sb);
      chk($sformatf("rnd%0d_latency", i), 128'(lat), 128'd65);
      chk($sformatf("rnd%0d_result", i), {hi, lo}, model(s, a, b));
      tick();
    end

    mt_data = 64'h1234; mtlo_we = 1'b1; tick(); mtlo_we = 1'b0;
    chk("mtlo", 128'(lo), 128'h1234);
    mt_data = 64'h5678; mthi_we = 1'b1; tick(); mthi_we = 1'b0;
    chk("mthi", 128'(hi), 128'h5678);

    launch(1'b0, 64'd7, 64'd6);
    repeat (9) tick();
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort_busy", 128'(busy), 128'd0);
    chk("abort_done", 128'(done), 128'd0);
    chk("abort_hilo", {hi, lo}, {64'h5678, 64'h1234});
    cnt = 0;
    for (int i = 0; i < 70; i++) begin
      if (done) cnt++;
      tick();
    end
    chk("abort_no_done", 128'(cnt), 128'd0);

    abort = 1'b1;
    launch(1'b0, 64'd2, 64'd2);
    abort = 1'b0;
    chk("abort_beats_start", 128'(busy), 128'd0);

    launch(1'b0, 64'd7, 64'd6);
    repeat (19) tick();
    launch(1'b1, 64'd9, 64'd9);
    wait_done(lat2, bc, sb);
    chk("ignored_start_latency", 128'(lat2 + 20), 128'd65);
    chk("ignored_start_result", {hi, lo}, 128'd42);
    tick();

    mt_data = 64'hAAAA; mthi_we = 1'b1;
    launch(1'b0, 64'd2, 64'd3);
    mthi_we = 1'b0;
    chk("mt_with_start", 128'(hi), 128'hAAAA);
    wait_done(lat, bc, sb);
    chk("mt_with_start_result", {hi, lo}, 128'd6);
    tick();

    rd_req = 1'b1;
    launch(1'b1, -64'sd3, 64'd5);
    wait_done(lat, bc, sb);
    chk("stall_busy", 128'(sb), 128'd0);
    chk("stall_done_cycle", 128'(stall), 128'd0);
    chk("neg_result", {hi, lo}, model(1'b1, -64'sd3, 64'd5));
    launch(1'b0, 64'd100, 64'd200);
    chk("b2b_accepted", 128'(busy), 128'd1);
    wait_done(lat, bc, sb);
    chk("b2b_latency", 128'(lat), 128'd65);
    chk("b2b_result", {hi, lo}, 128'd20000);
    rd_req = 1'b0;
    tick();

    launch(1'b0, 64'd11, 64'd13);
    repeat (20) tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 128'(busy), 128'd0);
    chk("arst_done", 128'(done), 128'd0);
    chk("arst_hilo", {hi, lo}, 128'd0);
    #1 rst = 1'b0;
    tick();
    launch(1'b1, -64'sd4, -64'sd5);
    wait_done(lat, bc, sb);
    chk("post_rst_latency", 128'(lat), 128'd65);
    chk("post_rst_result", {hi, lo}, 128'd20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
